audio_clip_streamer: RTL and testbench

//  Sample-streaming stage between the game-event logic and the audio codec. It takes
//  one-cycle sound requests (start, chomp, eatghost, death) and arbitrates them by

---
 rtl/audio_pkg.sv | 37 +++
 rtl/clip_request_arbiter.sv | 41 ++++
 rtl/audio_clip_streamer.sv | 146 ++++++++++++++
 tb/tb_audio_clip_streamer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - clip identifiers, ROM clip map and PCM conversion shared by the streamer
package audio_pkg;

   typedef enum logic [1:0] {
      CLIP_CHOMP    = 2'd0,
      CLIP_EATGHOST = 2'd1,
      CLIP_START    = 2'd2,
      CLIP_DEATH    = 2'd3
   } clip_t;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_WAIT  = 2'd2,
      S_WRITE = 2'd3
   } stream_state_t;

   // Clip layout in the music ROM .mif, indexed by clip_t.
   localparam int unsigned CLIP_BASE [4] = '{32'h0000, 32'h0100, 32'h0200, 32'h0300};
   localparam int unsigned CLIP_LEN  [4] = '{32'd2, 32'd3, 32'd4, 32'd3};

   function automatic bit clip_map_fits(input int addr_w);
      for (int i = 0; i < 4; i++) begin
         if (CLIP_LEN[i] == 0) return 1'b0;
         if (longint'(CLIP_BASE[i]) + longint'(CLIP_LEN[i]) > (longint'(1) << addr_w)) return 1'b0;
      end
      return 1'b1;
   endfunction

   // Offset-binary ROM byte to signed 24-bit PCM, with optional attenuation.
   function automatic logic [23:0] to_pcm(input logic [7:0] rom_byte, input int shift);
      logic signed [23:0] pcm;
      pcm = $signed({rom_byte ^ 8'h80, 16'h0000});
      return pcm >>> shift;
   endfunction

endpackage

// File: rtl/clip_request_arbiter.sv
// rtl/clip_request_arbiter.sv - priority pick of sound requests against the active clip
// Chomp requests that lose arbitration are remembered in a one-deep pending flag.
module clip_request_arbiter
   import audio_pkg::*;
(
   input  logic  CLOCK_50,
   input  logic  reset,
   input  logic  req_chomp_i,
   input  logic  req_eatghost_i,
   input  logic  req_start_i,
   input  logic  req_death_i,
   input  logic  busy_i,
   input  clip_t active_id_i,
   input  logic  pending_clear_i,
   output logic  accept_o,
   output clip_t id_o,
   output logic  chomp_pending_o
);

   logic any_req;
   logic pending_q, pending_d;

   always_comb begin
      id_o = CLIP_CHOMP;
      if (req_death_i)         id_o = CLIP_DEATH;
      else if (req_start_i)    id_o = CLIP_START;
      else if (req_eatghost_i) id_o = CLIP_EATGHOST;
      any_req  = req_chomp_i | req_eatghost_i | req_start_i | req_death_i;
      accept_o = any_req && (!busy_i || (id_o > active_id_i));
      pending_d = (pending_q && !pending_clear_i) ||
                  (req_chomp_i && !(accept_o && (id_o == CLIP_CHOMP)));
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) pending_q <= 1'b0;
      else       pending_q <= pending_d;
   end

   assign chomp_pending_o = pending_q;

endmodule

// File: rtl/audio_clip_streamer.sv
// rtl/audio_clip_streamer.sv - plays ROM clips as repeated 24-bit PCM frames into the codec
// In IDLE the codec is fed silence whenever it is ready.
module audio_clip_streamer
   import audio_pkg::*;
#(
   parameter int ADDR_W     = 16,
   parameter int ROM_LAT    = 1,
   parameter int SAMPLE_REP = 6,
   parameter int VOL_SHIFT  = 0
) (
   input  logic              CLOCK_50,
   input  logic              reset,
   input  logic              req_start,
   input  logic              req_chomp,
   input  logic              req_eatghost,
   input  logic              req_death,
   input  logic [7:0]        rom_q,
   input  logic              write_ready,
   output logic [ADDR_W-1:0] rom_address,
   output logic              write,
   output logic [23:0]       writedata_left,
   output logic [23:0]       writedata_right,
   output logic              busy,
   output logic [1:0]        clip_id,
   output logic              clip_done
);

   localparam int REP_W = $clog2(SAMPLE_REP + 1);
   localparam int LAT_W = $clog2(ROM_LAT + 2);

   if (!clip_map_fits(ADDR_W)) begin : g_clip_map_check
      $error("clip ranges exceed the ROM address space");
   end

   stream_state_t     state_q;
   logic [ADDR_W-1:0] addr_q;
   logic [REP_W-1:0]  rep_q;
   logic [LAT_W-1:0]  lat_q;
   logic [23:0]       sample_q;
   logic [23:0]       data_q;
   clip_t             id_q;
   logic              done_q;

   logic              accept;
   clip_t             acc_id;
   logic              chomp_pending;
   logic              pending_clear;
   logic              frame_last;
   logic              clip_end;
   logic [ADDR_W-1:0] clip_last_addr;

   clip_request_arbiter u_arbiter (
      .CLOCK_50        (CLOCK_50),
      .reset           (reset),
      .req_chomp_i     (req_chomp),
      .req_eatghost_i  (req_eatghost),
      .req_start_i     (req_start),
      .req_death_i     (req_death),
      .busy_i          (busy),
      .active_id_i     (id_q),
      .pending_clear_i (pending_clear),
      .accept_o        (accept),
      .id_o            (acc_id),
      .chomp_pending_o (chomp_pending)
   );

   always_comb begin
      clip_last_addr = ADDR_W'(CLIP_BASE[id_q] + CLIP_LEN[id_q] - 32'd1);
      frame_last     = (rep_q == REP_W'(SAMPLE_REP - 1));
      clip_end       = (state_q == S_WRITE) && frame_last && !(addr_q < clip_last_addr);
      pending_clear  = clip_end && chomp_pending && !accept;
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_q  <= S_IDLE;
         addr_q   <= '0;
         rep_q    <= '0;
         lat_q    <= '0;
         sample_q <= '0;
         data_q   <= '0;
         id_q     <= CLIP_CHOMP;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (accept) begin
            // New or preempting clip restarts at its base; the aborted clip gets no done.
            state_q <= S_FETCH;
            addr_q  <= ADDR_W'(CLIP_BASE[acc_id]);
            rep_q   <= '0;
            lat_q   <= '0;
            id_q    <= acc_id;
         end else begin
            case (state_q)
               S_IDLE: ;
               S_FETCH: begin
                  if (lat_q == LAT_W'(ROM_LAT)) begin
                     sample_q <= to_pcm(rom_q, VOL_SHIFT);
                     lat_q    <= '0;
                     state_q  <= S_WAIT;
                  end else begin
                     lat_q <= lat_q + LAT_W'(1);
                  end
               end
               S_WAIT: begin
                  if (write_ready) begin
                     data_q  <= sample_q;
                     state_q <= S_WRITE;
                  end
               end
               S_WRITE: begin
                  if (!frame_last) begin
                     rep_q   <= rep_q + REP_W'(1);
                     state_q <= S_WAIT;
                  end else if (addr_q < clip_last_addr) begin
                     addr_q  <= addr_q + ADDR_W'(1);
                     rep_q   <= '0;
                     state_q <= S_FETCH;
                  end else begin
                     done_q <= 1'b1;
                     rep_q  <= '0;
                     if (chomp_pending) begin
                        addr_q  <= ADDR_W'(CLIP_BASE[CLIP_CHOMP]);
                        id_q    <= CLIP_CHOMP;
                        state_q <= S_FETCH;
                     end else begin
                        data_q  <= '0;
                        state_q <= S_IDLE;
                     end
                  end
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   assign rom_address     = addr_q;
   assign write           = (state_q == S_WRITE) || ((state_q == S_IDLE) && write_ready);
   assign writedata_left  = data_q;
   assign writedata_right = data_q;
   assign busy            = (state_q != S_IDLE);
   assign clip_id         = id_q;
   assign clip_done       = done_q;

endmodule

// File: tb/tb_audio_clip_streamer.sv
// tb/tb_audio_clip_streamer.sv - directed vector bench for audio_clip_streamer
module tb_audio_clip_streamer;

   logic        CLOCK_50 = 1'b0;
   logic        reset;
   logic        req_start, req_chomp, req_eatghost, req_death;
   logic [7:0]  rom_q;
   logic        write_ready;
   logic [15:0] rom_address;
   logic        write;
   logic [23:0] writedata_left, writedata_right;
   logic        busy;
   logic [1:0]  clip_id;
   logic        clip_done;

   audio_clip_streamer dut (
      .CLOCK_50        (CLOCK_50),
      .reset           (reset),
      .req_start       (req_start),
      .req_chomp       (req_chomp),
      .req_eatghost    (req_eatghost),
      .req_death       (req_death),
      .rom_q           (rom_q),
      .write_ready     (write_ready),
      .rom_address     (rom_address),
      .write           (write),
      .writedata_left  (writedata_left),
      .writedata_right (writedata_right),
      .busy            (busy),
      .clip_id         (clip_id),
      .clip_done       (clip_done)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   function automatic logic [7:0] rom_byte(input logic [15:0] a);
      case (a)
         16'h0200: return 8'h80;
         16'h0201: return 8'hFF;
         16'h0202: return 8'h00;
         16'h0203: return 8'h40;
         default:  return {a[1:0], 6'h15};
      endcase
   endfunction

   always @(posedge CLOCK_50) rom_q <= rom_byte(rom_address);

   typedef struct {
      logic [3:0]  req;
      logic [1:0]  id;
      logic [15:0] base;
      int          writes;
      int          dones;
      logic [1:0]  id_done1;
   } vec_t;

   vec_t        vecs [8];
   logic [23:0] exp_pcm [4];

   int tests_run = 0;
   int tests_failed = 0;
   int cyc = 0;
   int wr_mode = 2;
   int n_writes, n_done, lr_bad;
   logic [1:0]  id_at_done1;
   logic        busy_at_done1;
   logic [23:0] wq [$];
   logic [15:0] aq [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic clear_mon();
      n_writes = 0;
      n_done = 0;
      lr_bad = 0;
      id_at_done1 = 2'b00;
      busy_at_done1 = 1'b0;
      wq.delete();
      aq.delete();
   endtask

   task automatic step();
      @(posedge CLOCK_50);
      #1;
      cyc++;
      if (busy && write) begin
         n_writes++;
         wq.push_back(writedata_left);
         aq.push_back(rom_address);
         if (writedata_right !== writedata_left) lr_bad++;
      end
      if (clip_done) begin
         n_done++;
         if (n_done == 1) begin
            id_at_done1 = clip_id;
            busy_at_done1 = busy;
         end
      end
      case (wr_mode)
         0:       write_ready = 1'b1;
         1:       write_ready = ((cyc % 8) == 0);
         default: write_ready = 1'b0;
      endcase
   endtask

   task automatic pulse(input logic [3:0] r);
      {req_death, req_start, req_eatghost, req_chomp} = r;
      step();
      {req_death, req_start, req_eatghost, req_chomp} = 4'b0000;
   endtask

   task automatic run_to_idle(input string name);
      int k = 0;
      while (busy && k < 3000) begin
         step();
         k++;
      end
      check({name, " timeout"}, {31'b0, busy}, 32'd0);
   endtask

   initial begin
      vecs[0] = '{4'b0001, 2'd0, 16'h0000, 12, 1, 2'd0};
      vecs[1] = '{4'b0010, 2'd1, 16'h0100, 18, 1, 2'd1};
      vecs[2] = '{4'b0100, 2'd2, 16'h0200, 24, 1, 2'd2};
      vecs[3] = '{4'b1000, 2'd3, 16'h0300, 18, 1, 2'd3};
      vecs[4] = '{4'b1111, 2'd3, 16'h0300, 30, 2, 2'd0};
      vecs[5] = '{4'b0011, 2'd1, 16'h0100, 30, 2, 2'd0};
      vecs[6] = '{4'b0110, 2'd2, 16'h0200, 24, 1, 2'd2};
      vecs[7] = '{4'b1100, 2'd3, 16'h0300, 18, 1, 2'd3};
      exp_pcm[0] = 24'h000000;
      exp_pcm[1] = 24'h7F0000;
      exp_pcm[2] = 24'h800000;
      exp_pcm[3] = 24'hC00000;

      reset = 1'b1;
      {req_death, req_start, req_eatghost, req_chomp} = 4'b0000;
      write_ready = 1'b0;
      clear_mon();
      step();
      step();
      check("rst busy", {31'b0, busy}, 32'd0);
      check("rst write", {31'b0, write}, 32'd0);
      check("rst data", {8'b0, writedata_left}, 32'd0);
      check("rst done", {31'b0, clip_done}, 32'd0);
      check("rst addr", {16'b0, rom_address}, 32'd0);
      check("rst id", {30'b0, clip_id}, 32'd0);
      reset = 1'b0;
      step();

      // Start clip with the codec ready only every 8th cycle.
      wr_mode = 1;
      clear_mon();
      pulse(4'b0100);
      check("t1 addr", {16'b0, rom_address}, 32'h200);
      run_to_idle("t1");
      check("t1 writes", n_writes, 24);
      check("t1 dones", n_done, 1);
      check("t1 busy", {31'b0, busy}, 32'd0);
      check("t1 lr", lr_bad, 0);
      for (int k = 0; k < wq.size() && k < 24; k++) begin
         check($sformatf("t1 data%0d", k), {8'b0, wq[k]}, {8'b0, exp_pcm[k / 6]});
         check($sformatf("t1 addr%0d", k), {16'b0, aq[k]}, 32'h200 + k / 6);
      end

      wr_mode = 0;
      step();
      foreach (vecs[i]) begin
         clear_mon();
         pulse(vecs[i].req);
         check($sformatf("v%0d busy", i), {31'b0, busy}, 32'd1);
         check($sformatf("v%0d id", i), {30'b0, clip_id}, {30'b0, vecs[i].id});
         check($sformatf("v%0d addr", i), {16'b0, rom_address}, {16'b0, vecs[i].base});
         run_to_idle($sformatf("v%0d", i));
         check($sformatf("v%0d writes", i), n_writes, vecs[i].writes);
         check($sformatf("v%0d dones", i), n_done, vecs[i].dones);
         check($sformatf("v%0d id_done1", i), {30'b0, id_at_done1}, {30'b0, vecs[i].id_done1});
         check($sformatf("v%0d busy_done1", i), {31'b0, busy_at_done1}, (vecs[i].dones == 2) ? 32'd1 : 32'd0);
         check($sformatf("v%0d lr", i), lr_bad, 0);
         step();
         step();
      end

      // Death preempts a playing chomp.
      clear_mon();
      pulse(4'b0001);
      repeat (5) step();
      check("t3 no early done", n_done, 0);
      pulse(4'b1000);
      check("t3 addr", {16'b0, rom_address}, 32'h300);
      check("t3 id", {30'b0, clip_id}, 32'd3);
      check("t3 done at preempt", n_done, 0);
      n_writes = 0;
      run_to_idle("t3");
      check("t3 writes", n_writes, 18);
      check("t3 dones", n_done, 1);
      step();

      // Three chomps during death merge into one trailing chomp.
      clear_mon();
      pulse(4'b1000);
      repeat (3) begin
         repeat (3) step();
         pulse(4'b0001);
      end
      check("t4 id", {30'b0, clip_id}, 32'd3);
      run_to_idle("t4");
      check("t4 writes", n_writes, 30);
      check("t4 dones", n_done, 2);
      check("t4 id_done1", {30'b0, id_at_done1}, 32'd0);
      check("t4 busy_done1", {31'b0, busy_at_done1}, 32'd1);
      step();

      // Reset while waiting for the codec.
      wr_mode = 2;
      clear_mon();
      pulse(4'b0010);
      repeat (4) step();
      check("t6 waiting", {31'b0, busy}, 32'd1);
      reset = 1'b1;
      step();
      check("t6 busy", {31'b0, busy}, 32'd0);
      check("t6 write", {31'b0, write}, 32'd0);
      check("t6 data", {8'b0, writedata_left}, 32'd0);
      check("t6 addr", {16'b0, rom_address}, 32'd0);
      reset = 1'b0;
      repeat (3) step();
      check("t6 no done", n_done, 0);
      write_ready = 1'b1;
      #1;
      check("t6 idle write hi", {31'b0, write}, 32'd1);
      check("t6 idle data", {8'b0, writedata_left}, 32'd0);
      write_ready = 1'b0;
      #1;
      check("t6 idle write lo", {31'b0, write}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule
